// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory and holds one decoded word behind a valid/ready handshake.
// Optional build macro SKIP_NOP_EN drops NOP words (opcode 4'hF) at fetch instead of passing them downstream.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [3:0]        HALT_OPC = 4'b1110
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_instr,
    input  logic               i_redirect_valid,
    input  logic [ADDR_W-1:0]  i_redirect_addr,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0]  o_out_pc,
    output logic [3:0]         o_out_opcode,
    output logic [3:0]         o_out_rd,
    output logic [3:0]         o_out_rs,
    output logic [7:0]         o_out_imm,
    output logic               o_out_is_nop,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    localparam logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(16'hF000);

    state_t             r_state, w_state_next;
    logic [ADDR_W-1:0]  r_pc, w_pc_next;
    logic               r_out_valid, w_out_valid_next;
    logic [INSTR_W-1:0] r_out_instr, w_out_instr_next;
    logic [ADDR_W-1:0]  r_out_pc, w_out_pc_next;

    logic w_halt_stop;
    logic w_accept;
    logic w_load;
    logic w_skip;

    assign w_halt_stop = r_out_valid && (r_out_instr[15:12] == HALT_OPC);
    assign w_accept    = r_out_valid && i_out_ready;
    assign w_load      = (!r_out_valid || i_out_ready) && !w_halt_stop;

`ifdef SKIP_NOP_EN
    assign w_skip = (i_imem_instr[15:12] == 4'hF);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_out_instr <= NOP_WORD;
            r_out_pc    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_out_valid <= w_out_valid_next;
            r_out_instr <= w_out_instr_next;
            r_out_pc    <= w_out_pc_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_out_valid_next = r_out_valid;
        w_out_instr_next = r_out_instr;
        w_out_pc_next    = r_out_pc;
        case (r_state)
            S_IDLE, S_HALTED: begin
                if (i_start) begin
                    w_state_next     = S_RUN;
                    w_pc_next        = RESET_PC;
                    w_out_valid_next = 1'b0;
                end
            end
            S_RUN: begin
                if (i_redirect_valid) begin
                    w_pc_next        = i_redirect_addr;
                    w_out_valid_next = 1'b0;
                end else if (w_accept && w_halt_stop) begin
                    // Halt word consumed: stop with pc already pointing past it.
                    w_state_next     = S_HALTED;
                    w_out_valid_next = 1'b0;
                end else if (w_load) begin
                    w_pc_next = r_pc + ADDR_W'(1);
                    if (w_skip) begin
                        w_out_valid_next = 1'b0;
                    end else begin
                        w_out_valid_next = 1'b1;
                        w_out_instr_next = i_imem_instr;
                        w_out_pc_next    = r_pc;
                    end
                end
            end
            default: begin
                w_state_next     = S_IDLE;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    assign o_imem_addr  = r_pc;
    assign o_out_valid  = r_out_valid;
    assign o_out_instr  = r_out_instr;
    assign o_out_pc     = r_out_pc;
    assign o_out_opcode = r_out_instr[15:12];
    assign o_out_rd     = r_out_instr[11:8];
    assign o_out_rs     = r_out_instr[7:4];
    assign o_out_imm    = r_out_instr[7:0];
    assign o_busy       = (r_state == S_RUN);

`ifdef SKIP_NOP_EN
    assign o_out_is_nop = 1'b0;
`else
    assign o_out_is_nop = (r_out_instr[15:12] == 4'hF);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus randomized backpressure/redirect traffic
// checked against a program-order model of which words must reach downstream.
module tb_instr_fetch_unit;

`ifdef SKIP_NOP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_addr = 8'h00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic [3:0]  out_opcode, out_rd, out_rs;
    logic [7:0]  out_imm;
    logic        out_is_nop;
    logic        busy;

    logic [15:0] mem [0:255];
    int total = 0;
    int bad = 0;

    assign imem_instr = mem[imem_addr];
    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_start          (start),
        .o_imem_addr      (imem_addr),
        .i_imem_instr     (imem_instr),
        .i_redirect_valid (redirect_valid),
        .i_redirect_addr  (redirect_addr),
        .o_out_valid      (out_valid),
        .i_out_ready      (out_ready),
        .o_out_instr      (out_instr),
        .o_out_pc         (out_pc),
        .o_out_opcode     (out_opcode),
        .o_out_rd         (out_rd),
        .o_out_rs         (out_rs),
        .o_out_imm        (out_imm),
        .o_out_is_nop     (out_is_nop),
        .o_busy           (busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
        step; step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step;
        start = 1'b0;
    endtask

    task automatic load_plan;
        for (int a = 0; a < 256; a++) mem[a] = 16'h2000 | 16'(a);
        mem[0] = 16'hF000; mem[1] = 16'h0102; mem[2] = 16'h0103; mem[3] = 16'hF000;
        mem[4] = 16'h1510; mem[5] = 16'hF000; mem[6] = 16'h5510;
    endtask

    // Words downstream must see when fetching addresses lo..hi in order.
    task automatic expected_words(input int lo, input int hi, output logic [7:0] q[$]);
        q = {};
        for (int a = lo; a <= hi; a++)
            if (!(SKIP && mem[8'(a)][15:12] == 4'hF)) q.push_back(8'(a));
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", imem_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (out_instr !== 16'hF000) begin bad++; $display("FAIL reset_instr: got %h want F000", out_instr); end
        total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", out_pc); end
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_stream;
        logic [7:0] exp_q[$];
        int n = 0;
        do_reset;
        load_plan;
        expected_words(0, 6, exp_q);
        out_ready = 1'b1;
        pulse_start;
        for (int c = 0; c < 16 && n < exp_q.size(); c++) begin
            if (out_valid) begin
                $display("stream txn pc=%h instr=%h cycle=%0d", out_pc, out_instr, c);
                total++; if (out_pc !== exp_q[n]) begin bad++; $display("FAIL stream_pc: got %h want %h", out_pc, exp_q[n]); end
                total++; if (out_instr !== mem[exp_q[n]]) begin bad++; $display("FAIL stream_instr: got %h want %h", out_instr, mem[exp_q[n]]); end
                total++; if (c !== int'(exp_q[n]) + 1) begin bad++; $display("FAIL stream_latency: cycle %0d want %0d", c, int'(exp_q[n]) + 1); end
                total++; if (out_is_nop !== (!SKIP && mem[exp_q[n]][15:12] == 4'hF)) begin bad++; $display("FAIL stream_is_nop: got %b at pc %h", out_is_nop, out_pc); end
                total++; if ({out_opcode, out_rd, out_rs} !== mem[exp_q[n]][15:4] || out_imm !== mem[exp_q[n]][7:0]) begin
                    bad++; $display("FAIL stream_fields: got %h/%h/%h/%h for %h", out_opcode, out_rd, out_rs, out_imm, mem[exp_q[n]]);
                end
                if (out_pc == 8'h04) begin
                    total++; if (out_opcode !== 4'h1 || out_rd !== 4'h5 || out_rs !== 4'h1) begin bad++; $display("FAIL stream_pc4_fields: got %h %h %h want 1 5 1", out_opcode, out_rd, out_rs); end
                end
                if (out_pc == 8'h01) begin
                    total++; if (out_imm !== 8'h02) begin bad++; $display("FAIL stream_pc1_imm: got %h want 02", out_imm); end
                end
                n++;
            end
            step;
        end
        total++; if (n != exp_q.size()) begin bad++; $display("FAIL stream_count: got %0d want %0d", n, exp_q.size()); end
    endtask

    task automatic wait_pc2(input string tag);
        bit found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (out_valid && out_pc == 8'h02) found = 1'b1;
            else step;
        end
        total++; if (!found) begin bad++; $display("FAIL %s_wait_pc2: got timeout want out_pc=02", tag); end
    endtask

    task automatic test_stall;
        logic [7:0] exp_q[$];
        int n = 0;
        do_reset;
        load_plan;
        out_ready = 1'b1;
        pulse_start;
        wait_pc2("stall");
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            total++; if (out_valid !== 1'b1 || out_instr !== 16'h0103 || out_pc !== 8'h02) begin
                bad++; $display("FAIL stall_hold: got v=%b instr=%h pc=%h want 1/0103/02", out_valid, out_instr, out_pc);
            end
            total++; if (imem_addr !== 8'h03) begin bad++; $display("FAIL stall_addr: got %h want 03", imem_addr); end
        end
        out_ready = 1'b1;
        expected_words(2, 6, exp_q);
        for (int c = 0; c < 12 && n < exp_q.size(); c++) begin
            if (out_valid) begin
                $display("stall txn pc=%h instr=%h", out_pc, out_instr);
                total++; if (out_pc !== exp_q[n] || out_instr !== mem[exp_q[n]]) begin
                    bad++; $display("FAIL stall_resume: got pc=%h instr=%h want pc=%h", out_pc, out_instr, exp_q[n]);
                end
                n++;
            end
            step;
        end
        total++; if (n != exp_q.size()) begin bad++; $display("FAIL stall_count: got %0d want %0d", n, exp_q.size()); end
    endtask

    task automatic test_redirect;
        do_reset;
        load_plan;
        out_ready = 1'b1;
        pulse_start;
        wait_pc2("redir");
        redirect_valid = 1'b1;
        redirect_addr  = 8'h06;
        step;
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_squash: got %b want 0", out_valid); end
        step;
        $display("redirect txn pc=%h instr=%h", out_pc, out_instr);
        total++; if (out_valid !== 1'b1 || out_pc !== 8'h06 || out_instr !== 16'h5510) begin
            bad++; $display("FAIL redir_target: got v=%b pc=%h instr=%h want 1/06/5510", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_halt;
        logic [7:0] exp_q[$];
        int n = 0;
        do_reset;
        load_plan;
        mem[2] = 16'hE000;
        expected_words(0, 2, exp_q);
        out_ready = 1'b1;
        pulse_start;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                $display("halt txn pc=%h instr=%h", out_pc, out_instr);
                total++;
                if (n >= exp_q.size()) begin bad++; $display("FAIL halt_extra: got pc=%h want none", out_pc); end
                else if (out_pc !== exp_q[n]) begin bad++; $display("FAIL halt_pc: got %h want %h", out_pc, exp_q[n]); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL halt_busy_run: got %b want 1", busy); end
                n++;
            end
            step;
        end
        total++; if (n != exp_q.size()) begin bad++; $display("FAIL halt_count: got %0d want %0d", n, exp_q.size()); end
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL halt_stopped: got busy=%b v=%b want 0/0", busy, out_valid); end
        total++; if (imem_addr !== 8'h03) begin bad++; $display("FAIL halt_pc_frozen: got %h want 03", imem_addr); end
        expected_words(0, 2, exp_q);
        pulse_start;
        n = 0;
        for (int c = 0; c < 6 && n == 0; c++) begin
            if (out_valid) begin
                total++; if (out_pc !== exp_q[0]) begin bad++; $display("FAIL halt_restart: got %h want %h", out_pc, exp_q[0]); end
                n++;
            end
            step;
        end
        total++; if (n != 1) begin bad++; $display("FAIL halt_restart_timeout: got none want pc=%h", exp_q[0]); end
    endtask

    task automatic test_wrap;
        do_reset;
        load_plan;
        mem[8'hFF] = 16'h0107;
        mem[0]     = 16'h0200;
        out_ready = 1'b1;
        pulse_start;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFF;
        step;
        redirect_valid = 1'b0;
        step;
        total++; if (out_valid !== 1'b1 || out_pc !== 8'hFF || out_instr !== 16'h0107) begin
            bad++; $display("FAIL wrap_ff: got v=%b pc=%h instr=%h want 1/FF/0107", out_valid, out_pc, out_instr);
        end
        step;
        total++; if (out_valid !== 1'b1 || out_pc !== 8'h00 || out_instr !== 16'h0200) begin
            bad++; $display("FAIL wrap_00: got v=%b pc=%h instr=%h want 1/00/0200", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        load_plan;
        mem[0] = 16'h0200;
        out_ready = 1'b1;
        pulse_start;
        step;
        out_ready = 1'b0;
        step;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || imem_addr !== 8'h00 || busy !== 1'b0) begin
            bad++; $display("FAIL areset_now: got v=%b addr=%h busy=%b want 0/00/0", out_valid, imem_addr, busy);
        end
        step;
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_idle_redirect;
        do_reset;
        redirect_valid = 1'b1;
        redirect_addr  = 8'h55;
        step;
        total++; if (imem_addr !== 8'h00 || busy !== 1'b0) begin bad++; $display("FAIL idle_redir: got addr=%h busy=%b want 00/0", imem_addr, busy); end
        start = 1'b1;
        step;
        start = 1'b0;
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 8'h00 || busy !== 1'b1) begin bad++; $display("FAIL start_wins: got addr=%h busy=%b want 00/1", imem_addr, busy); end
    endtask

    // Downstream must see the program in address order, resuming at each redirect target, ending at the halt.
    task automatic test_random;
        logic [7:0] exp_addr = 8'h00;
        int  redirects_left = 4;
        bit  halted = 1'b0;
        logic [3:0] op;
        do_reset;
        for (int a = 0; a < 256; a++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hE) op = 4'h3;
            mem[a] = {op, 12'($urandom)};
        end
        mem[40] = {4'hE, 12'($urandom)};
        pulse_start;
        for (int c = 0; c < 3000 && !halted; c++) begin
            if (busy && redirects_left > 0 && $urandom_range(0, 19) == 0) begin
                redirect_valid = 1'b1;
                redirect_addr  = 8'($urandom_range(0, 39));
                out_ready      = 1'b0;
            end else begin
                redirect_valid = 1'b0;
                out_ready      = ($urandom_range(0, 2) != 0);
            end
            if (out_valid && out_ready) begin
                while (SKIP && mem[exp_addr][15:12] == 4'hF) exp_addr = exp_addr + 8'd1;
                $display("random txn pc=%h instr=%h", out_pc, out_instr);
                total++; if (out_pc !== exp_addr || out_instr !== mem[exp_addr]) begin
                    bad++; $display("FAIL random_word: got pc=%h instr=%h want pc=%h instr=%h", out_pc, out_instr, exp_addr, mem[exp_addr]);
                end
                total++; if (out_is_nop !== (!SKIP && mem[exp_addr][15:12] == 4'hF)) begin bad++; $display("FAIL random_is_nop: got %b at pc %h", out_is_nop, out_pc); end
                if (mem[exp_addr][15:12] == 4'hE) halted = 1'b1;
                exp_addr = exp_addr + 8'd1;
            end
            if (redirect_valid) begin
                exp_addr = redirect_addr;
                redirects_left--;
            end
            step;
        end
        redirect_valid = 1'b0;
        total++; if (!halted) begin bad++; $display("FAIL random_timeout: got no halt want halt at 28"); end
        total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL random_halted: got busy=%b v=%b want 0/0", busy, out_valid); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_stall;
        test_redirect;
        test_halt;
        test_wrap;
        test_async_reset;
        test_idle_redirect;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage sitting between the program counter/instruction memory pair and the decode/execute logic.
- Owns the PC and drives the 8-bit read address into the combinational 256x16 instruction memory.
- Captures the returned 16-bit word into a single pipeline register with a valid/ready handshake.
- Pre-splits the word into opcode/register/immediate fields, and supports start, halt and PC redirect (jump/branch).

Parameters:
- ADDR_W, 8, PC and instruction-memory address width.
- INSTR_W, 16, instruction width; field split below assumes 16.
- RESET_PC, 8'h00, PC value loaded on reset and on the IDLE->RUN transition.
- HALT_OPC, 4'b1110, opcode that stops fetching once it is accepted downstream.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching from RESET_PC when IDLE or HALTED.
- imem_addr  out  ADDR_W  address to instruction memory; equals pc.
- imem_instr  in  INSTR_W  combinational read data for imem_addr.
- redirect_valid  in  1  load the PC with redirect_addr and flush the output register.
- redirect_addr  in  ADDR_W  jump/branch target.
- out_valid  out  1  output register holds a valid instruction.
- out_ready  in  1  downstream accepts the instruction this cycle.
- out_instr  out  INSTR_W  captured instruction word.
- out_pc  out  ADDR_W  address the instruction was fetched from.
- out_opcode  out  4  out_instr[15:12].
- out_rd  out  4  out_instr[11:8].
- out_rs  out  4  out_instr[7:4].
- out_imm  out  8  out_instr[7:0].
- out_is_nop  out  1  out_opcode == 4'b1111.
- busy  out  1  FSM is in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, pc=RESET_PC, out_valid=0, out_instr=16'hF000 (NOP), out_pc=0, busy=0.
  - Takes effect immediately, including mid-handshake; a pending instruction is discarded.
- States:
  - IDLE: no fetch. start -> RUN with pc=RESET_PC.
  - RUN: fetch as described below. Accepting a HALT_OPC word (out_valid & out_ready & out_opcode==HALT_OPC) -> HALTED.
  - HALTED: no fetch. out_valid stays 0. pc is frozen at the address after the halt. start -> RUN with pc=RESET_PC.
- Fetch rule, RUN only:
  - load = (!out_valid | out_ready) & !halt_stop, where halt_stop = output holds HALT_OPC. Fetching stops behind a halt.
  - On load: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+1.
  - On handshake with no load: out_valid<=0.
  - Otherwise hold all outputs and the pc (stall).
- Latency: the word at address A appears at out_instr one cycle after imem_addr==A. Throughput is 1 instruction/cycle while out_ready=1.
- Wrap: pc increments modulo 2^ADDR_W (255 -> 0); no flag is raised.
- Redirect (RUN only; ignored in IDLE/HALTED):
  - Highest priority over load and stall.
  - pc<=redirect_addr and out_valid<=0 in the same edge, so the in-flight word is squashed even if out_ready=1.
  - The first redirected word is valid 2 cycles after redirect_valid is sampled.
- start during RUN: ignored.
- start together with redirect_valid in IDLE: start wins; pc=RESET_PC.
- Decode fields are pure wires from out_instr and are valid only when out_valid=1.

Optional Feature:
- Macro: SKIP_NOP_EN.
- Defined:
  - A fetched word with opcode 4'b1111 is not loaded. out_valid<=0 (or holds if not yet accepted), and pc still increments.
  - NOPs never reach downstream; out_is_nop is tied to 0.
- Undefined: NOPs are passed through like any other word, with out_is_nop=1.

Test Plan:
- Memory {0:F000, 1:0102, 2:0103, 3:F000, 4:1510, 5:F000, 6:5510}; reset, start, out_ready=1 -> out_pc 0,1,2,...,6 on consecutive cycles; at pc=4 out_opcode=1, out_rd=5, out_rs=1; at pc=1 out_imm=02; out_is_nop=1 at pc 0,3,5 (SKIP_NOP_EN undefined).
- Same memory, out_ready=0 for 3 cycles while out_pc=2 -> out_instr holds 0103, imem_addr holds 3, no word is lost after out_ready returns to 1.
- redirect_valid=1, redirect_addr=6 while out_pc=2 is valid with out_ready=1 -> out_valid=0 next cycle, then out_pc=6, out_instr=5510.
- memory[2]=E000, out_ready=1 -> words 0,1,2 are accepted, busy drops after pc 2 is accepted, out_valid stays 0; a later start pulse restarts at out_pc=0.
- redirect_addr=FF with memory[FF]=0107 -> out_pc=FF, then out_pc=00 (wrap).
- Assert rst_n=0 mid-stall with out_valid=1 -> out_valid=0, imem_addr=00 immediately, without waiting for a clock edge. With SKIP_NOP_EN defined, the first scenario yields only out_pc 1,2,4,6.
